// File: rtl/stream_demux_1x4.sv
// Registered 1-to-4 stream demultiplexer. Each accepted input beat is
// steered by in_sel into one of four one-entry output slots. A slot that
// is draining this cycle can be refilled in the same cycle, so a single
// output sustains one beat per cycle. Each output keeps an 8-bit wrapping
// count of completed transfers.
module stream_demux_1x4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [31:0]        out_cnt
);

  logic [3:0]       valid;
  logic [WIDTH-1:0] data [4];
  logic [7:0]       cnt  [4];
  logic [3:0]       drain;
  logic [3:0]       load;
  logic             accept;

  // A slot is free when empty or being drained this cycle; only the
  // addressed slot gates the input, so a stalled output blocks only its own beats.
  assign in_ready = ~valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  // Per-slot drain and load strobes.
  always_comb begin
    drain = valid & out_ready;
    load  = 4'b0000;
    load[in_sel] = accept;
  end

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_slot
      // Slot state: a load wins over a drain, and the drain still counts.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid[k] <= 1'b0;
          data[k]  <= '0;
          cnt[k]   <= 8'd0;
        end else begin
          if (drain[k]) begin
            cnt[k] <= cnt[k] + 8'd1;
          end
          if (load[k]) begin
            valid[k] <= 1'b1;
            data[k]  <= in_data;
          end else if (drain[k]) begin
            valid[k] <= 1'b0;
          end
        end
      end

      assign out_data[k*WIDTH +: WIDTH] = data[k];
      assign out_cnt[k*8 +: 8]          = cnt[k];
    end
  endgenerate

  assign out_valid = valid;

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Scoreboard bench for stream_demux_1x4. Stimulus drives on the falling
// edge; a monitor samples just before each rising edge, keeps one queue of
// expected beats per output plus a model transfer count, and checks every
// handshake, payload and count against that model.
module tb_stream_demux_1x4;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [31:0]        out_cnt;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sbq [4][$];
  logic [7:0]       mcnt [4];

  stream_demux_1x4 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample 1 time unit before each rising edge.
  initial begin
    logic exp_rdy;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          sbq[k].delete();
          mcnt[k] = 8'd0;
        end
      end else begin
        exp_rdy = (sbq[in_sel].size() == 0) || out_ready[in_sel];
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
          check($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
                {31'd0, sbq[k].size() != 0});
          check($sformatf("out_cnt[%0d]", k), {24'd0, out_cnt[k*8 +: 8]}, {24'd0, mcnt[k]});
          if (sbq[k].size() != 0)
            check($sformatf("out_data[%0d]", k), {24'd0, out_data[k*WIDTH +: WIDTH]},
                  {24'd0, sbq[k][0]});
        end
        for (int k = 0; k < 4; k++) begin
          if (sbq[k].size() != 0 && out_ready[k]) begin
            void'(sbq[k].pop_front());
            mcnt[k] = mcnt[k] + 8'd1;
          end
        end
        if (in_valid && exp_rdy) sbq[in_sel].push_back(in_data);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [1:0] sel, input logic [7:0] d, input int max_wait);
    bit ok = 0;
    in_valid = 1'b1; in_sel = sel; in_data = d;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (in_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      failures++; checks++;
      $display("FAIL send_timeout sel=%0d actual=no_accept required=accept", sel);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] c3;
    rst_n = 1'b0; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
    #1;
    check("reset out_valid", {28'd0, out_valid}, 32'h0);
    check("reset out_data", out_data, 32'h0);
    check("reset out_cnt", out_cnt, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Routing: one beat per output, all consumers stalled.
    for (int i = 0; i < 4; i++) send(2'(i), 8'hA0 + 8'(i), 2);
    #1;
    check("route out_valid", {28'd0, out_valid}, 32'hF);
    check("route out_data", out_data, 32'hA3A2A1A0);
    in_valid = 1; in_sel = 2; in_data = 8'hEE;
    #1;
    check("route full in_ready", {31'd0, in_ready}, 32'h0);
    @(negedge clk);
    in_valid = 0;
    out_ready = 4'hF;
    repeat (2) @(negedge clk);
    out_ready = 4'h0;

    // Streaming: 20 back-to-back beats to output 1.
    do_reset();
    out_ready = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_sel = 1; in_data = 8'(8'h30 + i);
      #1;
      check("stream in_ready", {31'd0, in_ready}, 32'h1);
      @(negedge clk);
    end
    in_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    check("stream cnt1", {24'd0, out_cnt[15:8]}, 32'd20);
    out_ready = 4'h0;

    // No head-of-line blocking: slot 0 stuck full, sel 2 keeps flowing.
    send(2'd0, 8'h55, 2);
    out_ready = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sel = 0; in_data = 8'($urandom);
      #1;
      check("hol sel0 blocked", {31'd0, in_ready}, 32'h0);
      @(negedge clk);
      in_sel = 2; in_data = 8'($urandom);
      #1;
      check("hol sel2 flows", {31'd0, in_ready}, 32'h1);
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 4'hF;
    repeat (2) @(negedge clk);
    out_ready = 4'h0;

    // Simultaneous drain and load on slot 3.
    send(2'd3, 8'h11, 2);
    #1;
    c3 = out_cnt[31:24];
    out_ready = 4'b1000; in_valid = 1; in_sel = 3; in_data = 8'h22;
    #1;
    check("simul in_ready", {31'd0, in_ready}, 32'h1);
    @(negedge clk);
    out_ready = 4'h0; in_valid = 0;
    #1;
    check("simul valid3", {31'd0, out_valid[3]}, 32'h1);
    check("simul data3", {24'd0, out_data[31:24]}, 32'h22);
    check("simul cnt3", {24'd0, out_cnt[31:24]}, {24'd0, c3 + 8'd1});
    @(negedge clk);
    out_ready = 4'hF;
    repeat (2) @(negedge clk);
    out_ready = 4'h0;

    // Wrap: 257 drains on output 2 after a fresh reset.
    do_reset();
    out_ready = 4'b0100;
    for (int i = 0; i < 257; i++) send(2'd2, 8'(i), 2);
    repeat (2) @(negedge clk);
    #1;
    check("wrap cnt", out_cnt, 32'h0001_0000);
    @(negedge clk);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      out_ready = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom);
      in_data   = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 0;

    // Reset mid-stream with slots 1 and 3 full and nonzero counts.
    out_ready = 4'hF;
    @(negedge clk);
    out_ready = 4'h0;
    send(2'd1, 8'h77, 2);
    send(2'd3, 8'h99, 2);
    #1;
    check("prereset valid", {28'd0, out_valid}, 32'b1010);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", {28'd0, out_valid}, 32'h0);
    check("midreset out_cnt", out_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("postreset in_ready sel%0d", s), {31'd0, in_ready}, 32'h1);
    end
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

endmodule

// File: doc/stream_demux_1x4.md
# stream_demux_1x4

Registered 1-to-4 stream demultiplexer. It steers each beat accepted on a single valid/ready input stream to one of four output streams, selected per beat by `in_sel`. It is the distribution-side counterpart of the team's 4:1 selection muxes, used wherever one producer feeds four consumers. Each output has its own one-entry holding register and an 8-bit wrapping count of completed output transfers.

## Interface
- `WIDTH`, default 8: payload width in bits.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: input beat present.
- `in_ready`  output  1: input beat accepted this cycle when `in_valid & in_ready`.
- `in_data`  input  WIDTH: input payload.
- `in_sel`  input  2: destination index 0..3, qualified by `in_valid`.
- `out_valid`  output  4: bit k = output k holds a beat.
- `out_ready`  input  4: bit k = consumer k takes the beat this cycle.
- `out_data`  output  4*WIDTH: output k payload at `[k*WIDTH +: WIDTH]`.
- `out_cnt`  output  32: output k completed-transfer count at `[k*8 +: 8]`.

## Operation
- Per output k, a one-entry slot holds `valid_k` and `data_k`.
- Slot k is free when `!valid_k | out_ready[k]`. This is a bubble-free drain-and-refill.
- `in_ready = free(in_sel)`, computed combinationally from `out_valid`, `out_ready` and `in_sel` only. It never depends on `in_valid`.
- Accept happens when `in_valid & in_ready`. At the clock edge, `data_{in_sel} <= in_data` and `valid_{in_sel} <= 1`.
- Output drain happens when `out_valid[k] & out_ready[k]`:
  - `valid_k <= 0`, unless the same slot is loaded that cycle.
  - `cnt_k <= cnt_k + 1`, modulo 256, wrapping 255 -> 0 with no flag.
- Simultaneous drain and load on the same slot k: the new data is loaded, `valid_k` stays 1, and `cnt_k` still increments.
- Drains on other slots proceed in the same cycle, independently of any accept. Up to four drains and one accept can occur per cycle.
- `in_sel` and `in_data` are sampled only at the accept. They may change freely while `in_ready` is low, and the route follows the current `in_sel`.
- A stalled output k blocks only beats addressed to k. Beats for other outputs keep flowing, so there is no head-of-line blocking across outputs.
- `data_k` holds its last value after a drain. Its value is meaningless while `out_valid[k] = 0`.
- Once `out_valid[k]` is asserted, `out_data` slice k must stay stable until that slot is drained.

## Timing
- Reset values: `out_valid = 4'b0000`, `out_data = 0`, `out_cnt = 0`.
- `in_ready` is combinational. It is 1 during reset only in the sense that all slots are empty; no accept occurs while `rst_n = 0`.
- Reset asserted mid-operation: all held beats are discarded and counts clear immediately (asynchronously).
- After `rst_n` deasserts, the first accept is possible on the first rising edge.
- Latency: a beat accepted at edge N appears with `out_valid[k] = 1` after edge N, i.e. one cycle.
- Throughput: one beat per cycle to any single output whose consumer holds `out_ready` high.
- No combinational path from `in_valid` or `in_data` to any output. The only combinational path is `out_ready`/`in_sel` -> `in_ready`.
- `out_cnt` updates on the edge that completes the drain, and is visible in the following cycle.

## Test plan
- **Reset:** assert `rst_n = 0` mid-stream with slots 1 and 3 full -> `out_valid = 0000` and `out_cnt = 0` immediately. After release, `in_ready = 1` for every `in_sel`.
- **Routing:** send beats 0xA0..0xA3 with `in_sel` = 0,1,2,3 and all `out_ready = 0` -> `out_valid = 1111`, `out_data = 0xA3A2A1A0` (WIDTH = 8). A 5th beat with `in_sel = 2` -> `in_ready = 0`, and the beat is held by the source.
- **Streaming:** 20 back-to-back beats to output 1 with `out_ready[1] = 1` -> `in_ready` is high every cycle, output 1 sees the data in order at 1-cycle latency, and `out_cnt[15:8] = 20`.
- **No head-of-line blocking:** `out_ready[0] = 0` with slot 0 full; alternate `in_sel` 0/2 -> sel-0 beats stall, while sel-2 beats are accepted and drained each time they are presented.
- **Simultaneous drain and load:** slot 3 full with 0x11, `out_ready[3] = 1`, input 0x22 to `in_sel = 3` in the same cycle -> accepted; next cycle `out_valid[3] = 1`, data is 0x22, and `cnt_3` has incremented by 1.
- **Wrap:** 257 drains on output 2 -> `out_cnt[23:16] = 1`, and the other counts are unchanged.
